// File: rtl/aes_axis_tx_pkg.sv
// Shared sizes and FSM state type for the AES output-RAM stream drain.
package aes_axis_tx_pkg;

    localparam int WORD_S = 32;
    localparam int BLK_S  = 128;
    localparam int BYTE_S = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LD,
        ST_SEND,
        ST_FIN
    } tx_state_t;

endpackage

// File: rtl/aes_axis_tx_if.sv
// AXI4-Stream beat bundle; master drives data/valid/last, slave drives ready.
interface aes_axis_tx_if #(
    parameter int DATA_W = 32
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/aes_axis_tx.sv
// Reads blk_cnt blocks from the AES output RAM and serializes each block into
// AXIS_DATA_WIDTH-bit stream beats, first word taken from the low-index end.
module aes_axis_tx
    import aes_axis_tx_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 9,
    parameter int FIFO_DATA_WIDTH = BLK_S,
    parameter int AXIS_DATA_WIDTH = WORD_S
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FIFO_ADDR_WIDTH-1:0] blk_cnt,
    output logic                       fifo_r_e,
    output logic [FIFO_ADDR_WIDTH-1:0] fifo_addr,
    input  logic [0:FIFO_DATA_WIDTH-1] fifo_data,
    aes_axis_tx_if.master              m_axis,
    output logic                       busy,
    output logic                       done
);

    localparam int BEATS  = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    tx_state_t                  r_state;
    tx_state_t                  w_next;
    logic [FIFO_ADDR_WIDTH-1:0] r_blk_cnt;
    logic [FIFO_ADDR_WIDTH-1:0] r_blk_idx;
    logic [BEAT_W-1:0]          r_word_idx;
    logic [0:FIFO_DATA_WIDTH-1] r_shift;

    logic w_tvalid;
    logic w_hs;
    logic w_last_word;
    logic w_last_blk;
    logic w_accept;

    assign w_tvalid    = (r_state == ST_SEND);
    assign w_hs        = w_tvalid && m_axis.tready;
    assign w_last_word = (r_word_idx == BEAT_W'(BEATS - 1));
    assign w_last_blk  = (r_blk_idx == r_blk_cnt - FIFO_ADDR_WIDTH'(1));
    // FIN also accepts start so a new transfer can begin in the done cycle
    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_cnt  <= '0;
            r_blk_idx  <= '0;
            r_word_idx <= '0;
            r_shift    <= '0;
        end else begin
            if (w_accept && (blk_cnt != '0)) begin
                r_blk_cnt <= blk_cnt;
                r_blk_idx <= '0;
            end
            if (r_state == ST_LD) begin
                r_shift    <= fifo_data;
                r_word_idx <= '0;
            end
            if (w_hs) begin
                r_shift    <= r_shift << AXIS_DATA_WIDTH;
                r_word_idx <= r_word_idx + BEAT_W'(1);
                if (w_last_word && !w_last_blk) begin
                    r_blk_idx <= r_blk_idx + FIFO_ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_FIN: begin
                if (w_accept) begin
                    w_next = (blk_cnt != '0) ? ST_RD : ST_FIN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD:   w_next = ST_LD;
            ST_LD:   w_next = ST_SEND;
            ST_SEND: begin
                if (w_hs && w_last_word) begin
                    w_next = w_last_blk ? ST_FIN : ST_RD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Every output decodes from flops only, so none of them has a combinational input path
    always_comb begin
        fifo_r_e      = (r_state == ST_RD);
        fifo_addr     = r_blk_idx;
        busy          = (r_state == ST_RD) || (r_state == ST_LD) || (r_state == ST_SEND);
        done          = (r_state == ST_FIN);
        m_axis.tvalid = w_tvalid;
        m_axis.tdata  = r_shift[0:AXIS_DATA_WIDTH-1];
        m_axis.tlast  = w_tvalid && w_last_word && w_last_blk;
    end

endmodule

// File: tb/tb_aes_axis_tx.sv
// Randomized bench for aes_axis_tx: a RAM model feeds the DUT and an expected-beat
// queue built from RAM contents checks data, order, tlast, stalls and latencies.
module tb_aes_axis_tx;

    logic         clk;
    logic         reset;
    logic         start;
    logic [8:0]   blk_cnt;
    logic         fifo_r_e;
    logic [8:0]   fifo_addr;
    logic [0:127] fifo_data;
    logic         busy;
    logic         done;

    logic [0:127] ram [0:511];

    int n_total;
    int n_bad;

    aes_axis_tx_if #(.DATA_W(32)) axis ();

    aes_axis_tx #(
        .FIFO_ADDR_WIDTH(9),
        .FIFO_DATA_WIDTH(128),
        .AXIS_DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .blk_cnt  (blk_cnt),
        .fifo_r_e (fifo_r_e),
        .fifo_addr(fifo_addr),
        .fifo_data(fifo_data),
        .m_axis   (axis.master),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency read port
    always @(posedge clk) begin
        if (fifo_r_e) fifo_data <= ram[fifo_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_ram(input int n);
        for (int b = 0; b < n; b++) begin
            ram[b] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // n blocks, pct = tready probability, mid = extra start/blk_cnt=7 mid-transfer,
    // chain >= 0 starts the next transfer in the predicted done cycle (pct must be 100),
    // pre = this transfer was already started in the previous done cycle
    task automatic do_xfer(input int n, input int pct, input bit mid, input int chain, input bit pre);
        logic [31:0]  q [$];
        logic [0:127] blk;
        logic [31:0]  w;
        logic [31:0]  pd;
        bit           pv, pr, pl, fin;
        int           cyc, re_cnt, last_hs, next_valid, hs_cnt;

        for (int b = 0; b < n; b++) begin
            blk = ram[b];
            for (int k = 0; k < 4; k++) q.push_back(blk[k*32 +: 32]);
        end
        if (!pre) begin
            @(posedge clk) #1;
            start   = 1'b1;
            blk_cnt = 9'(n);
        end
        @(posedge clk) #1;
        start   = 1'b0;
        blk_cnt = 9'($urandom);
        cyc = 1; last_hs = 0; next_valid = 3; re_cnt = 0; hs_cnt = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            axis.tready = ($urandom_range(0, 99) < pct);
            if (mid && cyc == 5) begin
                start   = 1'b1;
                blk_cnt = 9'd7;
            end
            if (chain >= 0 && cyc == 6 * n + 1) begin
                start   = 1'b1;
                blk_cnt = 9'(chain);
            end
            @(negedge clk);
            if (fifo_r_e) begin
                chk("raddr", fifo_addr, re_cnt);
                re_cnt++;
            end
            if (cyc == 1 && n > 0) chk("re_lat", fifo_r_e, 1);
            if (pv && !pr) begin
                chk("stall_v", axis.tvalid, 1);
                chk("stall_d", axis.tdata, pd);
                chk("stall_l", axis.tlast, pl);
            end
            if (axis.tvalid && !pv) chk("vlat", cyc, next_valid);
            if (axis.tvalid && axis.tready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    w = q.pop_front();
                    chk("tdata", axis.tdata, w);
                    chk("tlast", axis.tlast, q.size() == 0);
                end
                hs_cnt++;
                last_hs = cyc;
                if (hs_cnt % 4 == 0) next_valid = cyc + 3;
            end
            if (done) begin
                chk("done_lat", cyc, last_hs + 1);
                chk("left", q.size(), 0);
                chk("done_v", axis.tvalid, 0);
                chk("done_busy", busy, 0);
                fin = 1'b1;
            end else begin
                chk("busy", busy, n > 0);
            end
            pv = axis.tvalid; pr = axis.tready; pd = axis.tdata; pl = axis.tlast;
            cyc++;
            if (!fin) begin
                @(posedge clk) #1;
                start = 1'b0;
            end
        end
        chk("timeout", fin, 1);
        chk("re_cnt", re_cnt, n);
    endtask

    task automatic reset_midway();
        int hs, cyc, dn;
        fill_ram(3);
        @(posedge clk) #1;
        start = 1'b1; blk_cnt = 9'd3; axis.tready = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 200) begin
            @(negedge clk);
            if (axis.tvalid && axis.tready) hs++;
            cyc++;
            @(posedge clk) #1;
        end
        chk("rst_reach", hs, 5);
        reset = 1'b1;
        @(negedge clk);
        dn = int'(done);
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_v", axis.tvalid, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            dn += int'(done);
            @(negedge clk);
        end
        chk("rst_nodone", dn, 0);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0; blk_cnt = '0; axis.tready = 1'b0; fifo_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_re", fifo_r_e, 0);
        chk("rst_addr", fifo_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_busy0", busy, 0);

        ram[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        do_xfer(1, 100, 1'b0, -1, 1'b0);
        fill_ram(3);
        do_xfer(3, 100, 1'b0, -1, 1'b0);
        fill_ram(2);
        do_xfer(2, 50, 1'b0, -1, 1'b0);
        do_xfer(0, 100, 1'b0, -1, 1'b0);
        reset_midway();
        ram[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        do_xfer(1, 100, 1'b0, -1, 1'b0);
        fill_ram(8);
        do_xfer(3, 70, 1'b1, -1, 1'b0);
        fill_ram(4);
        do_xfer(2, 100, 1'b0, 4, 1'b0);
        do_xfer(4, 100, 1'b0, -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_ram(n);
            do_xfer(n, 60, 1'b0, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
